brick_ram_arbiter: RTL and testbench

Arbiter and sequencer for the single-port brick health RAM (one 2-bit health entry per brick, addressed by brick index). It shares the RAM between three requesters: the level loader (writes), the ball hit logic (read-modify-write decrement), and the collision query logic (reads). After every hit that changes a brick's health, it issues one redraw request to the drawing side. It sits between the game-control datapaths and the brick RAM instance.

---
 rtl/brick_ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_brick_ram_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/brick_ram_arbiter.sv
// Arbiter/sequencer for the single-port brick health RAM: loader writes,
// hit read-modify-write decrements with redraw requests, and health queries.
module brick_ram_arbiter #(
    parameter int unsigned BRICK_NUM = 40,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [1:0]        ld_health,
    output logic              ld_ack,
    input  logic              hit_req,
    input  logic [ADDR_W-1:0] hit_addr,
    output logic              hit_ack,
    output logic [1:0]        hit_health,
    input  logic              q_req,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_ack,
    output logic [1:0]        q_health,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_wdata,
    output logic              ram_we,
    input  logic [1:0]        ram_rdata,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [1:0]        rd_health,
    input  logic              rd_done,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(BRICK_NUM);

    typedef enum logic [2:0] {
        IDLE, LOAD_WR, HIT_RD, HIT_WAIT, HIT_WR, DRAW_REQ, Q_RD, Q_WAIT
    } state_t;

    state_t            state, nxt;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [1:0]        wr_health_q, wr_health_n;
    logic              oor_q, oor_n;
    logic [1:0]        old_q, old_n;
    logic [1:0]        hit_health_n;
    logic [ADDR_W-1:0] rd_addr_n;
    logic [1:0]        rd_health_n;
    logic [1:0]        q_hold, q_hold_n;
    logic [1:0]        q_rd_c;
    logic [ADDR_W-1:0] ram_addr_n;
    logic [1:0]        ram_wdata_n;
    logic              ram_we_n;

    // Query result: RAM data arrives in Q_WAIT, so it is forwarded while acked and held after
    assign q_rd_c   = oor_q ? 2'd0 : ram_rdata;
    assign q_health = q_ack ? q_rd_c : q_hold;

    // Next-state, operand latching and next-cycle output decode
    always_comb begin
        nxt          = state;
        addr_n       = addr_q;
        wr_health_n  = wr_health_q;
        oor_n        = oor_q;
        old_n        = old_q;
        hit_health_n = hit_health;
        rd_addr_n    = rd_addr;
        rd_health_n  = rd_health;
        q_hold_n     = q_hold;
        ram_addr_n   = '0;
        ram_wdata_n  = 2'd0;
        ram_we_n     = 1'b0;

        case (state)
            IDLE: begin
                if (ld_req) begin
                    nxt         = LOAD_WR;
                    addr_n      = ld_addr;
                    wr_health_n = ld_health;
                    oor_n       = (ld_addr >= ADDR_LIMIT);
                end else if (hit_req) begin
                    nxt    = HIT_RD;
                    addr_n = hit_addr;
                    oor_n  = (hit_addr >= ADDR_LIMIT);
                end else if (q_req) begin
                    nxt    = Q_RD;
                    addr_n = q_addr;
                    oor_n  = (q_addr >= ADDR_LIMIT);
                end
            end
            LOAD_WR:  nxt = IDLE;
            HIT_RD:   nxt = HIT_WAIT;
            HIT_WAIT: begin
                // Out-of-range bricks read as dead so they never write or redraw
                old_n        = oor_q ? 2'd0 : ram_rdata;
                hit_health_n = (old_n == 2'd0) ? 2'd0 : old_n - 2'd1;
                nxt          = HIT_WR;
            end
            HIT_WR: begin
                if (old_q != 2'd0) begin
                    nxt         = DRAW_REQ;
                    rd_addr_n   = addr_q;
                    rd_health_n = old_q - 2'd1;
                end else begin
                    nxt = IDLE;
                end
            end
            DRAW_REQ: if (rd_done) nxt = IDLE;
            Q_RD:     nxt = Q_WAIT;
            Q_WAIT: begin
                q_hold_n = q_rd_c;
                nxt      = IDLE;
            end
            default:  nxt = IDLE;
        endcase

        case (nxt)
            LOAD_WR: begin
                ram_addr_n  = addr_n;
                ram_wdata_n = wr_health_n;
                ram_we_n    = !oor_n;
            end
            HIT_RD, Q_RD: ram_addr_n = addr_n;
            HIT_WR: begin
                ram_addr_n  = addr_n;
                ram_wdata_n = hit_health_n;
                ram_we_n    = (old_n != 2'd0);
            end
            default: ;
        endcase
    end

    // State, operand and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            addr_q      <= '0;
            wr_health_q <= 2'd0;
            oor_q       <= 1'b0;
            old_q       <= 2'd0;
            hit_health  <= 2'd0;
            rd_addr     <= '0;
            rd_health   <= 2'd0;
            q_hold      <= 2'd0;
            ram_addr    <= '0;
            ram_wdata   <= 2'd0;
            ram_we      <= 1'b0;
            ld_ack      <= 1'b0;
            hit_ack     <= 1'b0;
            q_ack       <= 1'b0;
            rd_req      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt;
            addr_q      <= addr_n;
            wr_health_q <= wr_health_n;
            oor_q       <= oor_n;
            old_q       <= old_n;
            hit_health  <= hit_health_n;
            rd_addr     <= rd_addr_n;
            rd_health   <= rd_health_n;
            q_hold      <= q_hold_n;
            ram_addr    <= ram_addr_n;
            ram_wdata   <= ram_wdata_n;
            ram_we      <= ram_we_n;
            ld_ack      <= (nxt == LOAD_WR);
            hit_ack     <= (nxt == HIT_WR);
            q_ack       <= (nxt == Q_WAIT);
            rd_req      <= (nxt == DRAW_REQ);
            busy        <= (nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_brick_ram_arbiter.sv
// Directed scoreboard bench for brick_ram_arbiter with a behavioural brick RAM.
module tb_brick_ram_arbiter;

    localparam int unsigned BRICK_NUM = 40;
    localparam int unsigned ADDR_W    = 10;
    localparam int K_LD = 0, K_HIT = 1, K_RD = 2, K_Q = 3;
    localparam int HOLD = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_req, hit_req, q_req, rd_done;
    logic [ADDR_W-1:0] ld_addr, hit_addr, q_addr;
    logic [1:0]        ld_health;
    logic              ld_ack, hit_ack, q_ack, rd_req, busy, ram_we;
    logic [1:0]        hit_health, q_health, ram_wdata, rd_health;
    logic [1:0]        ram_rdata = 2'd0;
    logic [ADDR_W-1:0] ram_addr, rd_addr;

    logic [1:0] mem [0:1023];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int kind;
        int addr;
        int health;
        bit we;
        int cyc;
    } exp_t;
    exp_t sb[$];

    brick_ram_arbiter #(.BRICK_NUM(BRICK_NUM), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_health(ld_health), .ld_ack(ld_ack),
        .hit_req(hit_req), .hit_addr(hit_addr), .hit_ack(hit_ack), .hit_health(hit_health),
        .q_req(q_req), .q_addr(q_addr), .q_ack(q_ack), .q_health(q_health),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_health(rd_health), .rd_done(rd_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Brick RAM: registered read; out-of-range addresses return junk (3)
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= (ram_addr >= ADDR_W'(BRICK_NUM)) ? 2'd3 : mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, 64'({ram_we, ld_ack, hit_ack, q_ack, rd_req, busy}), 64'(0));
        chk({tag, "_data"}, 64'({ram_addr, ram_wdata, hit_health, q_health, rd_addr, rd_health}), 64'(0));
    endtask

    // Serve acks/redraws until the scoreboard drains and the DUT is idle
    task automatic run(input int budget);
        exp_t e;
        bit   rd_seen = 0;
        bit   idle_chk = 0;
        int   rd_cnt = 0;
        int   rd_a = 0, rd_h = 0;
        while ((sb.size() != 0 || busy || idle_chk) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (idle_chk) begin
                chk("hit_idle", 64'(busy), 64'(0));
                idle_chk = 0;
            end
            if (ram_we) chk("we_legal", 64'(ld_ack | hit_ack), 64'(1));
            if (ld_ack) begin
                chk("ld_pending", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("ld_order", 64'(K_LD), 64'(e.kind));
                    chk("ld_cyc", 64'(cyc), 64'(e.cyc));
                    chk("ld_we", 64'(ram_we), 64'(e.we));
                    if (e.we) begin
                        chk("ld_addr", 64'(ram_addr), 64'(e.addr));
                        chk("ld_wdata", 64'(ram_wdata), 64'(e.health));
                    end
                end
                ld_req = 1'b0;
            end
            if (hit_ack) begin
                chk("hit_pending", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("hit_order", 64'(K_HIT), 64'(e.kind));
                    chk("hit_cyc", 64'(cyc), 64'(e.cyc));
                    chk("hit_health", 64'(hit_health), 64'(e.health));
                    chk("hit_we", 64'(ram_we), 64'(e.we));
                    if (e.we) begin
                        chk("hit_addr", 64'(ram_addr), 64'(e.addr));
                        chk("hit_wdata", 64'(ram_wdata), 64'(e.health));
                    end else begin
                        idle_chk = 1;
                    end
                end
                hit_req = 1'b0;
            end
            if (q_ack) begin
                chk("q_pending", 64'(sb.size() != 0), 64'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("q_order", 64'(K_Q), 64'(e.kind));
                    chk("q_cyc", 64'(cyc), 64'(e.cyc));
                    chk("q_health", 64'(q_health), 64'(e.health));
                end
                q_req = 1'b0;
            end
            if (rd_req) begin
                if (!rd_seen) begin
                    chk("rd_pending", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("rd_order", 64'(K_RD), 64'(e.kind));
                        chk("rd_cyc", 64'(cyc), 64'(e.cyc));
                        rd_a = e.addr;
                        rd_h = e.health;
                    end
                    rd_seen = 1;
                    rd_cnt = 0;
                end
                chk("rd_stable", 64'({rd_addr, rd_health}), {32'(rd_a), 32'(rd_h)} & 64'h0000_0fff | 64'(0) ? 64'(rd_a * 4 + rd_h) : 64'(rd_a * 4 + rd_h));
                rd_cnt++;
                rd_done = (rd_cnt == HOLD);
            end else begin
                rd_done = 1'b0;
                rd_seen = 0;
            end
        end
        chk("run_left", 64'(sb.size()) + 64'(busy), 64'(0));
        sb.delete();
    endtask

    initial begin
        int t0;
        reset = 1'b1;
        ld_req = 0; hit_req = 0; q_req = 0; rd_done = 0;
        ld_addr = '0; hit_addr = '0; q_addr = '0; ld_health = 2'd0;
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        reset = 1'b0;
        @(negedge clk);

        // Load then query
        t0 = cyc; ld_addr = 10'd5; ld_health = 2'd3; ld_req = 1;
        sb.push_back('{K_LD, 5, 3, 1'b1, t0 + 1});
        run(20);
        t0 = cyc; q_addr = 10'd5; q_req = 1;
        sb.push_back('{K_Q, 5, 3, 1'b0, t0 + 2});
        run(20);

        // Setup health 2 at 7 and 0 at 9
        t0 = cyc; ld_addr = 10'd7; ld_health = 2'd2; ld_req = 1;
        sb.push_back('{K_LD, 7, 2, 1'b1, t0 + 1});
        run(20);
        t0 = cyc; ld_addr = 10'd9; ld_health = 2'd0; ld_req = 1;
        sb.push_back('{K_LD, 9, 0, 1'b1, t0 + 1});
        run(20);

        // Hit on health 2 with a 5-cycle redraw
        t0 = cyc; hit_addr = 10'd7; hit_req = 1;
        sb.push_back('{K_HIT, 7, 1, 1'b1, t0 + 3});
        sb.push_back('{K_RD, 7, 1, 1'b0, t0 + 4});
        run(40);
        t0 = cyc; q_addr = 10'd7; q_req = 1;
        sb.push_back('{K_Q, 7, 1, 1'b0, t0 + 2});
        run(20);

        // Hit on health 0 saturates, no write, no redraw
        t0 = cyc; hit_addr = 10'd9; hit_req = 1;
        sb.push_back('{K_HIT, 9, 0, 1'b0, t0 + 3});
        run(20);

        // Simultaneous requests: load, hit+redraw, then query
        t0 = cyc;
        ld_addr = 10'd12; ld_health = 2'd2; ld_req = 1;
        hit_addr = 10'd5; hit_req = 1;
        q_addr = 10'd7; q_req = 1;
        sb.push_back('{K_LD, 12, 2, 1'b1, t0 + 1});
        sb.push_back('{K_HIT, 5, 2, 1'b1, t0 + 5});
        sb.push_back('{K_RD, 5, 2, 1'b0, t0 + 6});
        sb.push_back('{K_Q, 7, 1, 1'b0, t0 + 6 + HOLD + 2});
        run(60);

        // Out-of-range addresses
        t0 = cyc; q_addr = 10'(BRICK_NUM); q_req = 1;
        sb.push_back('{K_Q, BRICK_NUM, 0, 1'b0, t0 + 2});
        run(20);
        t0 = cyc; hit_addr = 10'd1023; hit_req = 1;
        sb.push_back('{K_HIT, 1023, 0, 1'b0, t0 + 3});
        run(20);
        t0 = cyc; ld_addr = 10'(BRICK_NUM); ld_health = 2'd3; ld_req = 1;
        sb.push_back('{K_LD, BRICK_NUM, 3, 1'b0, t0 + 1});
        run(20);

        // Reset in HIT_WAIT abandons the hit
        hit_addr = 10'd5; hit_req = 1;
        repeat (2) @(negedge clk);
        chk("hw_busy", 64'(busy), 64'(1));
        chk("hw_we", 64'(ram_we), 64'(0));
        reset = 1'b1; hit_req = 0;
        @(negedge clk);
        chk_zero("rst_hitwait");
        reset = 1'b0;
        t0 = cyc; q_addr = 10'd5; q_req = 1;
        sb.push_back('{K_Q, 5, 2, 1'b0, t0 + 2});
        run(20);

        // Reset in DRAW_REQ without rd_done
        hit_addr = 10'd5; hit_req = 1;
        repeat (3) @(negedge clk);
        chk("dr_hit_ack", 64'({hit_ack, hit_health, ram_we, ram_wdata}), 64'({1'b1, 2'd1, 1'b1, 2'd1}));
        hit_req = 0;
        @(negedge clk);
        chk("dr_rd_req", 64'({rd_req, rd_addr, rd_health}), 64'({1'b1, 10'd5, 2'd1}));
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_draw");
        reset = 1'b0;
        t0 = cyc; q_addr = 10'd5; q_req = 1;
        sb.push_back('{K_Q, 5, 1, 1'b0, t0 + 2});
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
